// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, fixed-point defaults and output saturation for the nn blocks.
package nn_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_FINISHED
    } state_t;

    // Rescale a Q(2*frac) accumulator to Q(frac), flooring, then clamp to a dw-bit signed range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                     input int unsigned frac,
                                                     input int unsigned dw);
        logic signed [63:0] s, hi, lo;
        s  = acc >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction
endpackage

// File: rtl/fixed_point_mac.sv
// fixed_point_mac: signed multiply-accumulate register, preloadable with a bias aligned to the product scale.
module fixed_point_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic [DATA_WIDTH-1:0]       bias_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       a_i,
    input  logic [DATA_WIDTH-1:0]       b_i,
    output logic signed [ACC_WIDTH-1:0] acc_o
);
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, bias_ext, prod_ext;
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'($signed(bias_i)) <<< FRAC_BITS;
    assign acc_d    = clear_i ? bias_ext : valid_i ? acc_q + prod_ext : acc_q;
    assign acc_o    = acc_q;

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end
endmodule

// File: rtl/dense_layer.sv
// dense_layer: fully-connected layer, one MAC per cycle against an external 1-cycle-latency weight memory.
module dense_layer
    import nn_pkg::*;
#(
    parameter int IN_LEN     = 128,
    parameter int OUT_LEN    = 128,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [IN_LEN*DATA_WIDTH-1:0]          input_vector,
    input  logic [OUT_LEN*DATA_WIDTH-1:0]         bias_vector,
    output logic                                  weight_rd_en,
    output logic [$clog2(IN_LEN*OUT_LEN)-1:0]     weight_addr,
    input  logic [DATA_WIDTH-1:0]                 weight_data,
    output logic [OUT_LEN*DATA_WIDTH-1:0]         output_vector,
    output logic                                  done,
    output logic                                  busy
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = $clog2(IN_LEN*OUT_LEN);
    localparam int IW = $clog2(IN_LEN);
    localparam int OW = $clog2(OUT_LEN);

    state_t                      state_q, state_d;
    logic [IW-1:0]               i_q, i_d, sel_q;
    logic [OW-1:0]               o_q, o_d, o_nxt;
    logic                        valid_q, done_q, done_d, clear;
    logic [IN_LEN*DW-1:0]        in_q, in_d;
    logic [OUT_LEN*DW-1:0]       bias_q, bias_d, out_q, out_d;
    logic [DW-1:0]               bias_sel, res;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [63:0]          res_wide;

    // o_nxt wraps at the last neuron so the bias select never indexes past the vector.
    assign o_nxt        = (o_q == OW'(OUT_LEN - 1)) ? '0 : o_q + 1'b1;
    assign clear        = (state_q == S_IDLE && enable) || state_q == S_WRITE;
    assign bias_sel     = (state_q == S_IDLE) ? bias_vector[DW-1:0] : bias_q[o_nxt*DW +: DW];
    assign res_wide     = sat_round(64'(acc), FRAC_BITS, DW);
    assign res          = res_wide[DW-1:0];
    assign weight_rd_en = state_q == S_MAC;
    assign weight_addr  = weight_rd_en ? AW'(o_q) * AW'(IN_LEN) + AW'(i_q) : '0;
    assign output_vector = out_q;
    assign done         = done_q;
    assign busy         = state_q == S_MAC || state_q == S_DRAIN || state_q == S_WRITE;

    fixed_point_mac #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear_i(clear),
        .bias_i (bias_sel),
        .valid_i(valid_q),
        .a_i    (in_q[sel_q*DW +: DW]),
        .b_i    (weight_data),
        .acc_o  (acc)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        o_d     = o_q;
        done_d  = done_q;
        in_d    = in_q;
        bias_d  = bias_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: if (enable) begin
                in_d    = input_vector;
                bias_d  = bias_vector;
                i_d     = '0;
                o_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                i_d     = i_q + 1'b1;
                state_d = (i_q == IW'(IN_LEN - 1)) ? S_DRAIN : S_MAC;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                out_d[o_q*DW +: DW] = res;
                i_d     = '0;
                o_d     = o_nxt;
                state_d = (o_q == OW'(OUT_LEN - 1)) ? S_FINISHED : S_MAC;
            end
            // done rises on the first FINISHED edge; release needs enable low afterwards.
            S_FINISHED: begin
                done_d  = done_q ? enable : 1'b1;
                state_d = (done_q && !enable) ? S_IDLE : S_FINISHED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            o_q     <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            in_q    <= '0;
            bias_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            sel_q   <= i_q;
            valid_q <= weight_rd_en;
            done_q  <= done_d;
            in_q    <= in_d;
            bias_q  <= bias_d;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: directed checks of dense_layer with a 4-input, 2-neuron configuration.
module tb_dense_layer;
    localparam int IN_LEN = 4;
    localparam int OUT_LEN = 2;
    localparam int DW = 16;

    logic                    clk = 1'b0;
    logic                    reset, enable;
    logic [IN_LEN*DW-1:0]    input_vector;
    logic [OUT_LEN*DW-1:0]   bias_vector;
    logic                    weight_rd_en;
    logic [2:0]              weight_addr;
    logic [DW-1:0]           weight_data = '0;
    logic [OUT_LEN*DW-1:0]   output_vector;
    logic                    done, busy;
    logic [DW-1:0]           wmem [IN_LEN*OUT_LEN];

    int checks = 0, failures = 0, cyc = 0, edges;
    int aq[$], cq[$];

    always #5 clk = ~clk;

    dense_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DATA_WIDTH(DW), .FRAC_BITS(8), .ACC_WIDTH(40)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .input_vector(input_vector), .bias_vector(bias_vector),
        .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_data(weight_data),
        .output_vector(output_vector), .done(done), .busy(busy)
    );

    always @(posedge clk) begin
        cyc++;
        if (weight_rd_en) begin
            weight_data <= wmem[weight_addr];
            aq.push_back(int'(weight_addr));
            cq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] a, b, c, d);
        input_vector = {d, c, b, a};
    endtask

    task automatic set_w(input logic [15:0] a, b, c, d, e, f, g, h);
        wmem[0] = a; wmem[1] = b; wmem[2] = c; wmem[3] = d;
        wmem[4] = e; wmem[5] = f; wmem[6] = g; wmem[7] = h;
    endtask

    // Called at a negedge with the DUT idle; returns edges from E0 until done is seen.
    task automatic run(output int n);
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_done(input string tag);
        enable = 1'b0;
        @(negedge clk);
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        input_vector = '0; bias_vector = '0;
        set_w(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rden", {31'd0, weight_rd_en}, 32'd0);
        check("rst_addr", {29'd0, weight_addr}, 32'd0);
        check("rst_out", output_vector, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: sum of {1,2,3,4} with unit weights, plus address trace
        set_in(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        bias_vector = '0;
        set_w(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        aq.delete(); cq.delete();
        run(edges);
        check("s1_latency", edges, 13);
        check("s1_out0", {16'd0, output_vector[15:0]}, 32'h0A00);
        check("s1_out1", {16'd0, output_vector[31:16]}, 32'h0A00);
        check("s4_rden_count", aq.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < aq.size()) check($sformatf("s4_addr%0d", k), aq[k], k);
        if (aq.size() == 8) begin
            check("s4_row0_contig", cq[3] - cq[0], 3);
            check("s4_gap", cq[4] - cq[3], 3);
        end
        release_done("s1");

        // 2: zero weights, output equals bias (negative preserved)
        set_w(0, 0, 0, 0, 0, 0, 0, 0);
        bias_vector = {16'h0080, 16'hFF00};
        run(edges);
        check("s2_latency", edges, 13);
        check("s2_out0", {16'd0, output_vector[15:0]}, 32'hFF00);
        check("s2_out1", {16'd0, output_vector[31:16]}, 32'h0080);
        release_done("s2");

        // mixed signs, floor toward -inf, distinct rows
        set_in(16'hFFFF, 16'h0200, 16'h0300, 16'h0400);
        bias_vector = {16'hFF00, 16'h0000};
        set_w(16'h0080, 0, 0, 0, 0, 0, 0, 16'h0200);
        run(edges);
        check("mx_out0_floor", {16'd0, output_vector[15:0]}, 32'hFFFF);
        check("mx_out1", {16'd0, output_vector[31:16]}, 32'h0700);
        release_done("mx");

        // 3: saturation both ways
        set_in(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        bias_vector = '0;
        set_w(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(edges);
        check("s3_pos0", {16'd0, output_vector[15:0]}, 32'h7FFF);
        check("s3_pos1", {16'd0, output_vector[31:16]}, 32'h7FFF);
        release_done("s3p");
        set_w(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run(edges);
        check("s3_neg0", {16'd0, output_vector[15:0]}, 32'h8000);
        check("s3_neg1", {16'd0, output_vector[31:16]}, 32'h8000);
        release_done("s3n");

        // 5: reset 5 edges into a run, then a clean re-run of scenario 1
        set_in(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        set_w(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        check("s5_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("s5_done", {31'd0, done}, 32'd0);
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_rden", {31'd0, weight_rd_en}, 32'd0);
        check("s5_out", output_vector, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(edges);
        check("s5_rerun_latency", edges, 13);
        check("s5_rerun_out", output_vector, 32'h0A000A00);

        // 6: enable held after done causes no restart
        aq.delete();
        repeat (10) @(negedge clk);
        check("s6_hold_rden", aq.size(), 0);
        check("s6_hold_done", {31'd0, done}, 32'd1);
        check("s6_hold_busy", {31'd0, busy}, 32'd0);
        release_done("s6");
        run(edges);
        check("s6_restart_latency", edges, 13);
        check("s6_restart_rden", aq.size(), 8);
        check("s6_restart_out", output_vector, 32'h0A000A00);
        release_done("s6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
